// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad column-scan controller.
// Holds the matrix dimensions, the key code type, the scan FSM state type and
// the row priority encoder used when more than one row reads high.

package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Accepted key, packed as {row[1:0], col[1:0]}
    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } kp_state_t;

    // Lowest-index high row wins; returns 3 when nothing is high, so callers
    // must qualify the result with an "any row high" test.
    function automatic logic [1:0] kp_row_prio(input logic [3:0] rows);
        logic [1:0] idx;
        if (rows[0]) begin
            idx = 2'd0;
        end else if (rows[1]) begin
            idx = 2'd1;
        end else if (rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_tick_gen.sv
// scan_tick_gen: column dwell counter for the keypad scanner.
// Counts 0..SCAN_DIV-1 and raises tick for the single cycle in which the
// count sits at SCAN_DIV-1; the count then wraps to 0. Synchronous reset.

module scan_tick_gen #(
    parameter int SCAN_DIV = 27000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST_COUNT);
    assign tick      = w_at_last;

    // Free-running dwell counter that wraps after the last count of a column dwell
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-scan controller for a 4x4 matrix keypad.
// Drives one column at a time, samples the rows once per dwell tick, debounces
// each press and release, and offers one {row,col} code per press over a
// valid/ready handshake. A press that arrives while a code is still pending is
// dropped and recorded in the sticky overrun flag.
// Optional build macro: KEYPAD_SYNC_EN adds a 2-flop synchronizer on filas_raw;
// without it the rows are sampled directly (simulation/bench builds).

module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 27000,
    parameter int DEBOUNCE_CNT = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] filas_raw,
    output logic [NUM_COLS-1:0] columnas,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held,
    output logic                overrun
);

    localparam logic [7:0] DB_TARGET = 8'(DEBOUNCE_CNT);

    logic                w_tick;
    logic [NUM_ROWS-1:0] w_rows;

    kp_state_t           r_state;
    logic [1:0]          r_col_idx;
    logic [NUM_COLS-1:0] r_columnas;
    logic [1:0]          r_row;
    logic [7:0]          r_db_cnt;
    logic [7:0]          r_rel_cnt;
    key_code_t           r_key_code;
    logic                r_key_valid;
    logic                r_key_held;
    logic                r_overrun;

    logic                w_any_row;
    logic [1:0]          w_prio_row;
    logic                w_row_high;
    logic [7:0]          w_db_next;
    logic [7:0]          w_rel_next;
    logic [1:0]          w_next_col;
    logic [NUM_COLS-1:0] w_next_onehot;
    logic                w_scan_accept;
    logic                w_db_accept;
    logic                w_emit;
    key_code_t           w_emit_code;
    logic                w_can_load;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

`ifdef KEYPAD_SYNC_EN
    logic [NUM_ROWS-1:0] r_sync_1;
    logic [NUM_ROWS-1:0] r_sync_2;

    // Two-flop synchronizer bringing the asynchronous row lines into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_1 <= '0;
            r_sync_2 <= '0;
        end else begin
            r_sync_1 <= filas_raw;
            r_sync_2 <= r_sync_1;
        end
    end

    assign w_rows = r_sync_2;
`else
    assign w_rows = filas_raw;
`endif

    assign w_any_row     = |w_rows;
    assign w_prio_row    = kp_row_prio(w_rows);
    assign w_row_high    = w_rows[r_row];
    assign w_db_next     = r_db_cnt + 8'd1;
    assign w_rel_next    = r_rel_cnt + 8'd1;
    assign w_next_col    = r_col_idx + 2'd1;
    assign w_next_onehot = NUM_COLS'(1) << w_next_col;

    // A press is accepted either straight out of SCAN (single-sample debounce)
    // or when the debounce count reaches its target in DEBOUNCE.
    assign w_scan_accept = (r_state == SCAN) && w_any_row && (DB_TARGET == 8'd1);
    assign w_db_accept   = (r_state == DEBOUNCE) && w_row_high && (w_db_next == DB_TARGET);
    assign w_emit        = w_tick && (w_scan_accept || w_db_accept);
    assign w_emit_code   = (r_state == SCAN) ? {w_prio_row, r_col_idx} : {r_row, r_col_idx};
    assign w_can_load    = !r_key_valid || key_ready;

    // Scan/debounce FSM together with the column drive and the key handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SCAN;
            r_col_idx   <= 2'd0;
            r_columnas  <= NUM_COLS'(1);
            r_row       <= 2'd0;
            r_db_cnt    <= 8'd0;
            r_rel_cnt   <= 8'd0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end

            if (w_emit) begin
                if (w_can_load) begin
                    r_key_code  <= w_emit_code;
                    r_key_valid <= 1'b1;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end

            if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (!w_any_row) begin
                            r_col_idx  <= w_next_col;
                            r_columnas <= w_next_onehot;
                        end else begin
                            r_row    <= w_prio_row;
                            r_db_cnt <= 8'd1;
                            if (DB_TARGET == 8'd1) begin
                                r_state    <= PRESSED;
                                r_key_held <= 1'b1;
                                r_rel_cnt  <= 8'd0;
                            end else begin
                                r_state <= DEBOUNCE;
                            end
                        end
                    end

                    DEBOUNCE: begin
                        if (w_row_high) begin
                            r_db_cnt <= w_db_next;
                            if (w_db_next == DB_TARGET) begin
                                r_state    <= PRESSED;
                                r_key_held <= 1'b1;
                                r_rel_cnt  <= 8'd0;
                            end
                        end else begin
                            r_state    <= SCAN;
                            r_db_cnt   <= 8'd0;
                            r_col_idx  <= w_next_col;
                            r_columnas <= w_next_onehot;
                        end
                    end

                    PRESSED: begin
                        if (w_row_high) begin
                            r_rel_cnt <= 8'd0;
                        end else if (w_rel_next == DB_TARGET) begin
                            r_state    <= SCAN;
                            r_key_held <= 1'b0;
                            r_rel_cnt  <= 8'd0;
                            r_db_cnt   <= 8'd0;
                            r_col_idx  <= w_next_col;
                            r_columnas <= w_next_onehot;
                        end else begin
                            r_rel_cnt <= w_rel_next;
                        end
                    end

                    default: begin
                        r_state <= SCAN;
                    end
                endcase
            end
        end
    end

    assign columnas  = r_columnas;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: self-checking bench for keypad_scan_ctrl with a small
// keypad matrix model (row r reads high when key (r,c) is down and column c is
// driven). Expected key codes are queued when a press is applied and compared
// when the controller raises key_valid.

module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic       clk;
    logic       rst;
    logic [3:0] filasRaw;
    logic [3:0] columnas;
    logic [3:0] keyCode;
    logic       keyValid;
    logic       keyReady;
    logic       keyHeld;
    logic       overrun;

    logic [3:0] pressedMat [4];
    logic [3:0] expQ [$];

    int checkCount;
    int failCount;

    keypad_scan_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .filas_raw (filasRaw),
        .columnas  (columnas),
        .key_code  (keyCode),
        .key_valid (keyValid),
        .key_ready (keyReady),
        .key_held  (keyHeld),
        .overrun   (overrun)
    );

    // Free-running board clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a row reads high when a pressed key sits in the driven column
    always_comb begin
        filasRaw = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            filasRaw[r] = |(pressedMat[r] & columnas);
        end
    end

    // Counts one comparison and reports it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presses or releases one key; a press may queue its expected code
    task automatic applyStimulus(input int row, input int col, input logic level, input logic expectCode);
        pressedMat[row][col] = level;
        if (expectCode) begin
            expQ.push_back({2'(row), 2'(col)});
        end
    endtask

    // Waits (bounded) for key_valid, then compares the code against the queue head
    task automatic waitValid(input string tag);
        logic [3:0] expCode;
        for (int i = 0; i < 300 && !keyValid; i++) @(negedge clk);
        checkOutput({tag, "_valid"}, keyValid, 1);
        if (keyValid && expQ.size() > 0) begin
            expCode = expQ.pop_front();
            checkOutput({tag, "_code"}, keyCode, expCode);
        end
    endtask

    // Waits (bounded) for key_held to reach a level
    task automatic waitHeld(input logic level, input string tag);
        for (int i = 0; i < 300 && keyHeld !== level; i++) @(negedge clk);
        checkOutput(tag, keyHeld, level);
    endtask

    // Waits (bounded) for a given column to be driven
    task automatic waitColumn(input logic [3:0] target, input string tag);
        for (int i = 0; i < 100 && columnas !== target; i++) @(negedge clk);
        checkOutput(tag, columnas, target);
    endtask

    // One-cycle ready pulse; key_valid must be low afterwards
    task automatic pulseReady(input string tag);
        keyReady = 1'b1;
        @(negedge clk);
        keyReady = 1'b0;
        checkOutput(tag, keyValid, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_col"}, columnas, 4'b0001);
        checkOutput({tag, "_code"}, keyCode, 4'b0000);
        checkOutput({tag, "_valid"}, keyValid, 0);
        checkOutput({tag, "_held"}, keyHeld, 0);
        checkOutput({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        logic [3:0] expCol;
        checkCount = 0;
        failCount  = 0;
        rst        = 1'b1;
        keyReady   = 1'b0;
        for (int r = 0; r < 4; r++) pressedMat[r] = 4'b0000;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkResetValues("reset");

        // Idle scan: one column step every SCAN_DIV cycles, wrapping 3 -> 0
        expCol = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            repeat (SCAN_DIV) @(negedge clk);
            expCol = {expCol[2:0], expCol[3]};
            checkOutput($sformatf("idle_col%0d", k), columnas, expCol);
            checkOutput($sformatf("idle_valid%0d", k), keyValid, 0);
        end

        // Hold key (1,2), accept it, then release
        applyStimulus(1, 2, 1'b1, 1'b1);
        waitValid("k12");
        checkOutput("k12_held", keyHeld, 1);
        checkOutput("k12_colfrozen", columnas, 4'b0100);
        pulseReady("k12_ready_drop");
        applyStimulus(1, 2, 1'b0, 1'b0);
        waitHeld(1'b0, "k12_release");
        checkOutput("k12_resume_col", columnas, 4'b1000);
        checkOutput("k12_ovr", overrun, 0);

        // Key (2,1) high for exactly one sampling tick, then low
        waitColumn(4'b0010, "bounce_col_wait");
        applyStimulus(2, 1, 1'b1, 1'b0);
        repeat (SCAN_DIV) @(negedge clk);
        applyStimulus(2, 1, 1'b0, 1'b0);
        repeat (SCAN_DIV) @(negedge clk);
        checkOutput("bounce_advance", columnas, 4'b0100);
        repeat (40) @(negedge clk);
        checkOutput("bounce_valid", keyValid, 0);
        checkOutput("bounce_held", keyHeld, 0);

        // Overrun: (0,0) stays pending, then (3,3) is lost
        applyStimulus(0, 0, 1'b1, 1'b1);
        waitValid("k00");
        applyStimulus(0, 0, 1'b0, 1'b0);
        waitHeld(1'b0, "k00_release");
        applyStimulus(3, 3, 1'b1, 1'b0);
        waitHeld(1'b1, "k33_held");
        checkOutput("ovr_code_kept", keyCode, 4'b0000);
        checkOutput("ovr_valid", keyValid, 1);
        checkOutput("ovr_flag", overrun, 1);
        applyStimulus(3, 3, 1'b0, 1'b0);
        waitHeld(1'b0, "k33_release");
        pulseReady("ovr_ready_drop");
        repeat (5) @(negedge clk);
        checkOutput("ovr_sticky", overrun, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetValues("ovr_reset");

        // Two keys in one column: lowest row wins
        applyStimulus(0, 1, 1'b1, 1'b1);
        applyStimulus(2, 1, 1'b1, 1'b0);
        waitValid("prio");
        pulseReady("prio_ready_drop");
        applyStimulus(0, 1, 1'b0, 1'b0);
        applyStimulus(2, 1, 1'b0, 1'b0);
        waitHeld(1'b0, "prio_release");

        // Reset in the middle of debounce (count 2) must not leak a key
        waitColumn(4'b1000, "mid_col_wait");
        applyStimulus(1, 3, 1'b1, 1'b0);
        repeat (2 * SCAN_DIV + 1) @(negedge clk);
        checkOutput("mid_pre_valid", keyValid, 0);
        rst = 1'b1;
        applyStimulus(1, 3, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        checkResetValues("mid_reset");
        repeat (60) @(negedge clk);
        checkOutput("mid_no_valid", keyValid, 0);
        checkOutput("mid_no_held", keyHeld, 0);

        checkOutput("queue_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Column-scan controller for the 4x4 matrix keypad on the 27 MHz board clock. It drives `columnas` one-hot, samples `filas_raw`, debounces each press and release, and hands one `{row,col}` key code per press to downstream logic over a valid/ready handshake. It sits in `module_top` between the keypad pins and the display/LED logic, and it owns the keypad resource exclusively.

## Interface
- `SCAN_DIV`, default 27000: clock cycles per column dwell (1 ms at 27 MHz); must be ≥ 4.
- `DEBOUNCE_CNT`, default 10: number of consecutive stable dwell samples needed to accept a press or a release; range 1..255.
- `clk`  in  1: board clock, 27 MHz.
- `rst`  in  1: reset, synchronous, active-high.
- `filas_raw`  in  4: keypad rows, active-high, asynchronous to `clk`.
- `columnas`  out  4: column drive, one-hot, active-high.
- `key_code`  out  4: accepted key, encoded as `{row[1:0], col[1:0]}`.
- `key_valid`  out  1: `key_code` is pending.
- `key_ready`  in  1: consumer accepts the pending code.
- `key_held`  out  1: the accepted key is still down (not yet release-debounced).
- `overrun`  out  1: sticky flag; a press was lost because a code was still pending.

## Operation
- Tick: dwell counter 0..SCAN_DIV-1. Tick asserts for one cycle when the counter reaches SCAN_DIV-1, then the counter wraps to 0.
- Rows are sampled only on a tick.
- Row priority: the lowest-index high row wins.
- States:
  - SCAN: at a tick, if no row is high, advance the column (3 wraps to 0). If any row is high, latch row and column, set debounce count to 1, go to DEBOUNCE. If DEBOUNCE_CNT is 1, go directly to PRESSED and emit the key.
  - DEBOUNCE: column frozen. At a tick, if the latched row is still high, increment the count; when it reaches DEBOUNCE_CNT, emit the key and go to PRESSED. If the row is low, advance the column and return to SCAN.
  - PRESSED: column frozen; `key_held` = 1. At a tick, a low row increments the release count and a high row clears it. When the release count reaches DEBOUNCE_CNT, clear `key_held`, advance the column, return to SCAN.
- Emit:
  - If `key_valid` is 0, or `key_ready` is 1 in the same cycle: load `key_code` and set `key_valid`.
  - Otherwise: keep the old code and set `overrun`.
- Handshake: `key_valid` stays high until a cycle where `key_ready` = 1. It drops on the next edge unless an emit occurs in that same cycle.
- `overrun` clears only on `rst`.
- Presses in other columns are ignored while in DEBOUNCE or PRESSED.

## Timing
- Reset values: `columnas` = 4'b0001, `key_code` = 0, `key_valid` = 0, `key_held` = 0, `overrun` = 0. State = SCAN, all counters 0.
- A `rst` asserted in any state, including mid-debounce, restores all reset values on the next edge. No partial key is emitted.
- `columnas` changes on the edge following a tick.
- `key_valid` and `key_held` rise on the edge following the accepting tick.
- Press-to-valid latency: (DEBOUNCE_CNT-1) × SCAN_DIV + 1 cycles after the first detecting tick, plus the synchronizer delay.
- Row-to-sample delay: 2 cycles with the synchronizer, 0 without.

## Configuration
- `KEYPAD_SYNC_EN` defined: `filas_raw` passes through a 2-flop synchronizer (reset to 0) before sampling.
- `KEYPAD_SYNC_EN` undefined: `filas_raw` is sampled directly. For simulation and benches only; all other behaviour is identical.

## Structure
- `keypad_pkg` holds:
  - `NUM_ROWS` = 4, `NUM_COLS` = 4
  - `key_code_t` (4 bits)
  - `kp_state_t` enum {SCAN, DEBOUNCE, PRESSED}
  - function `kp_row_prio(logic [3:0]) -> logic [1:0]`
- Sub-module `scan_tick_gen #(SCAN_DIV)`: dwell counter producing the one-cycle `tick`; cleared by `rst`.

## Test plan
All scenarios use `SCAN_DIV` = 4, `DEBOUNCE_CNT` = 3, and the bench matrix model `filas_raw[r] = pressed(r,c) & columnas[c]`.
- Reset, then idle: `columnas` = 0001 → 0010 → 0100 → 1000 → 0001, advancing one column every 4 cycles. `key_valid` stays 0.
- Hold key (1,2): after 3 stable ticks, `key_valid` = 1, `key_code` = 4'b0110, `key_held` = 1. Pulsing `key_ready` drops `key_valid` one cycle later. After release plus 3 ticks, `key_held` = 0 and scanning resumes from column 3.
- Key (2,1) bounced high for 1 tick then low: returns to SCAN, `key_valid` stays 0.
- `key_ready` held at 0; press/release (0,0), then press (3,3): `key_code` stays 4'b0000, `overrun` = 1. `overrun` survives a later `key_ready` and clears only on `rst`.
- Keys (0,1) and (2,1) held together: `key_code` = 4'b0001 (lowest row wins).
- `rst` pulsed at debounce count 2: all outputs return to reset values and no `key_valid` follows.
